vdg_vram_arbiter: RTL and testbench
===================================

# vdg_vram_arbiter

Single-port video RAM arbiter that sits directly upstream of the MC6847 display generator. It fetches the byte at the generator's display address DA and presents it on DD well before the generator latches it. In the remaining RAM slots it services CPU read/write requests through a req/ack handshake. Display fetches always take priority; CPU accesses fill the idle cycles between the generator's address changes, which occur at most once every 20 clk_25 cycles.

## Interface
- ADDR_W, 13, RAM and display address width (matches DA)
- DATA_W, 8, RAM data width (matches DD)

Ports:
- clk_25  in  1  pixel clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- DA  in  ADDR_W  display address from the MC6847 stage
- DD  out  DATA_W  display data to the MC6847 stage; registered
- cpu_req  in  1  CPU request, level; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle and held until the next read completes
- ram_addr  out  ADDR_W  RAM address; registered
- ram_we  out  1  RAM write enable; registered
- ram_wdata  out  DATA_W  RAM write data; registered
- ram_rdata  in  DATA_W  synchronous RAM read data; valid 2 edges after ram_addr is registered (RAM registers the address on the edge after ram_addr changes)

## Operation
- **Reset state:** while reset_n = 0, all outputs are 0, state = IDLE, last_da = 0, disp_pending = 1. This forces a fetch of the current DA on the first IDLE cycle after release.
- **disp_pending** is set on any edge where DA ≠ last_da. It is also set when a CPU write completes with cpu_addr == last_da, so DD is refreshed with the new byte.
- **FSM states:** IDLE, DISP_WAIT, DISP_CAP, CPU_WAIT, CPU_CAP, CPU_WR.
- **IDLE, display pending (priority):**
  - ram_addr ← DA, last_da ← DA, ram_we ← 0, clear disp_pending → DISP_WAIT.
- **IDLE, no display pending, cpu_req = 1 and cpu_ack = 0:**
  - Write: ram_addr ← cpu_addr, ram_wdata ← cpu_wdata, ram_we ← 1 → CPU_WR.
  - Read: ram_addr ← cpu_addr, ram_we ← 0 → CPU_WAIT.
- **IDLE, nothing pending:** stay in IDLE; ram_we stays 0; ram_addr holds its value.
- **DISP_WAIT → DISP_CAP.** In DISP_CAP: DD ← ram_rdata → IDLE.
- **CPU_WAIT → CPU_CAP.** In CPU_CAP: cpu_rdata ← ram_rdata, cpu_ack ← 1 → IDLE.
- **CPU_WR:** ram_we ← 0, cpu_ack ← 1 → IDLE. If cpu_addr == last_da, set disp_pending.
- **cpu_ack** is high for exactly one cycle per transaction.
- **Master rule:** the master deasserts cpu_req (or presents a new request) in the cycle cpu_ack is high. The block ignores cpu_req in the cycle cpu_ack is high, so one request never yields two transactions.
- **Reset mid-operation:** the FSM aborts asynchronously. ram_we drops immediately. An in-flight CPU transaction is lost without an ack; the master re-issues it. A write may or may not have reached the RAM.
- **DA changing while a display fetch is in flight:** the fetch completes with the old address; the new DA is fetched on the next IDLE.
- **Multiple DA changes while busy:** only the latest DA is fetched.
- **Address wrap:** addresses are used as given; there is no arithmetic.

## Timing
- **Display fetch latency:** 3 edges from acceptance in IDLE to DD update.
  - Worst case from a DA change to DD valid is 7 edges: 1 to sample, up to 3 for an in-progress CPU access, then 3 for the fetch.
  - This is below the 20-cycle minimum DA period, so DD is always valid when the generator latches.
- **CPU latency** from acceptance in IDLE:
  - Write: cpu_ack 2 edges later; the RAM write cycle is the edge after acceptance.
  - Read: cpu_ack and cpu_rdata 3 edges later.
- **CPU throughput:** one transaction per 3 cycles (write) or 4 cycles (read) when no display fetch is pending.
- **Simultaneous display-pending and cpu_req in IDLE:** display wins. The CPU is accepted on the next IDLE after DISP_CAP, i.e. 3 edges later.
- **CPU starvation bound:** at most one display fetch (3 cycles) precedes any CPU acceptance.

## Test plan
- **Reset fetch:** release reset_n with DA = 0x0000 and RAM[0] = 0xA5 → DD = 0xA5 exactly 3 edges after the first post-reset edge; ram_we stays 0 throughout.
- **Display tracking:** step DA 0x0000 → 0x0001 → 0x0002 every 20 cycles with RAM[n] = n + 0x10 → DD = 0x11, then 0x12, each 4 edges after the DA change.
- **CPU write then read:** write 0x3C to 0x0123 → ram_we high for exactly 1 cycle with ram_addr = 0x0123, cpu_ack 2 edges after acceptance. Then read 0x0123 → cpu_rdata = 0x3C with cpu_ack 3 edges after acceptance.
- **Collision:** DA changes to 0x0040 in the same cycle cpu_req (read 0x0200) arrives in IDLE → display fetch first (ram_addr = 0x0040), CPU read accepted on the next IDLE, both data correct.
- **Write to displayed address:** DA = 0x0005 steady with DD = 0x00; CPU writes 0xFF to 0x0005 → refetch scheduled, DD = 0xFF within 4 edges after cpu_ack.
- **Reset mid-read:** assert reset_n low in CPU_WAIT → no cpu_ack; all outputs are 0 asynchronously. After release, the re-issued read completes normally.

Source files
------------

// File: rtl/vdg_vram_arbiter.sv
// Video RAM arbiter: fetches the display byte at DA for the MC6847 stage and
// fills the remaining single-port RAM slots with CPU req/ack accesses.
module vdg_vram_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_25,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] DA,
  output logic [DATA_W-1:0] DD,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DISP_WAIT = 3'd1;
  localparam logic [2:0] DISP_CAP  = 3'd2;
  localparam logic [2:0] CPU_WAIT  = 3'd3;
  localparam logic [2:0] CPU_CAP   = 3'd4;
  localparam logic [2:0] CPU_WR    = 3'd5;

  logic [2:0]        state_q,        state_d;
  logic [ADDR_W-1:0] last_da_q,      last_da_d;
  logic              disp_pending_q, disp_pending_d;
  logic [DATA_W-1:0] dd_q,           dd_d;
  logic              cpu_ack_q,      cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q,    cpu_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q,     ram_addr_d;
  logic              ram_we_q,       ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q,    ram_wdata_d;

  // State and output registers; reset leaves a display fetch pending
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_da_q      <= '0;
      disp_pending_q <= 1'b1;
      dd_q           <= '0;
      cpu_ack_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      ram_addr_q     <= '0;
      ram_we_q       <= 1'b0;
      ram_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      last_da_q      <= last_da_d;
      disp_pending_q <= disp_pending_d;
      dd_q           <= dd_d;
      cpu_ack_q      <= cpu_ack_d;
      cpu_rdata_q    <= cpu_rdata_d;
      ram_addr_q     <= ram_addr_d;
      ram_we_q       <= ram_we_d;
      ram_wdata_q    <= ram_wdata_d;
    end
  end

  // Next-state logic: display fetch always outranks a CPU access in IDLE
  always_comb begin
    state_d        = state_q;
    last_da_d      = last_da_q;
    disp_pending_d = disp_pending_q | (DA != last_da_q);
    dd_d           = dd_q;
    cpu_ack_d      = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    ram_addr_d     = ram_addr_q;
    ram_we_d       = 1'b0;
    ram_wdata_d    = ram_wdata_q;

    case (state_q)
      IDLE: begin
        if (disp_pending_q) begin
          ram_addr_d     = DA;
          last_da_d      = DA;
          disp_pending_d = 1'b0;
          state_d        = DISP_WAIT;
        end else if (cpu_req && !cpu_ack_q) begin
          // cpu_ack_q high means this request was just served; ignore it
          ram_addr_d = cpu_addr;
          if (cpu_we) begin
            ram_wdata_d = cpu_wdata;
            ram_we_d    = 1'b1;
            state_d     = CPU_WR;
          end else begin
            state_d = CPU_WAIT;
          end
        end
      end
      DISP_WAIT: state_d = DISP_CAP;
      DISP_CAP: begin
        dd_d    = ram_rdata;
        state_d = IDLE;
      end
      CPU_WAIT: state_d = CPU_CAP;
      CPU_CAP: begin
        cpu_rdata_d = ram_rdata;
        cpu_ack_d   = 1'b1;
        state_d     = IDLE;
      end
      CPU_WR: begin
        cpu_ack_d = 1'b1;
        // A write over the displayed byte forces DD to be refreshed
        if (cpu_addr == last_da_q) begin
          disp_pending_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign DD        = dd_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vdg_vram_arbiter.sv
// Bench for vdg_vram_arbiter: directed scenarios plus random CPU/DA traffic,
// every cycle compared against a transaction-level scheduling model.
module tb_vdg_vram_arbiter;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk_25 = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] DA;
  logic [DATA_W-1:0] DD;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int vectors     = 0;
  int miscompares = 0;
  int wait_cyc    = 0;

  vdg_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_25    (clk_25),
    .reset_n   (reset_n),
    .DA        (DA),
    .DD        (DD),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #20 clk_25 = ~clk_25;

  // Synchronous single-port RAM: read data registered from the current address
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk_25) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  // Reference model: each accepted job blocks the RAM for a fixed slot count
  // and posts its result a fixed number of edges after acceptance.
  logic [DATA_W-1:0] smem [DEPTH];
  int                edge_n, free_at, dd_at, ack_at, hit_at;
  bit                pend, ack_rd, ack_prev, nxt_pend;
  logic [ADDR_W-1:0] m_last_da;
  logic [DATA_W-1:0] dd_val, rd_val;
  logic [DATA_W-1:0] e_dd, e_rdata, e_wdata;
  logic [ADDR_W-1:0] e_addr;
  logic              e_ack, e_we;

  always @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      edge_n = 0; free_at = 0; dd_at = -1; ack_at = -1; hit_at = -1;
      pend = 1'b1; m_last_da = '0; ack_rd = 1'b0;
      e_dd = '0; e_rdata = '0; e_wdata = '0; e_addr = '0; e_ack = 1'b0; e_we = 1'b0;
    end else begin
      edge_n++;
      ack_prev = e_ack;
      nxt_pend = pend || (DA != m_last_da) || (hit_at == edge_n);
      e_ack = 1'b0;
      e_we  = 1'b0;
      if (dd_at == edge_n) e_dd = dd_val;
      if (ack_at == edge_n) begin
        e_ack = 1'b1;
        if (ack_rd) e_rdata = rd_val;
      end
      if (edge_n >= free_at) begin
        if (pend) begin
          m_last_da = DA;
          nxt_pend  = 1'b0;
          e_addr    = DA;
          dd_val    = smem[DA];
          dd_at     = edge_n + 2;
          free_at   = edge_n + 3;
        end else if (cpu_req && !ack_prev) begin
          e_addr = cpu_addr;
          if (cpu_we) begin
            e_we  = 1'b1;
            e_wdata = cpu_wdata;
            smem[cpu_addr] = cpu_wdata;
            ack_rd  = 1'b0;
            ack_at  = edge_n + 1;
            if (cpu_addr == m_last_da) hit_at = edge_n + 1;
            free_at = edge_n + 2;
          end else begin
            rd_val  = smem[cpu_addr];
            ack_rd  = 1'b1;
            ack_at  = edge_n + 2;
            free_at = edge_n + 3;
          end
        end
      end
      pend = nxt_pend;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic compare_all();
    chk("dd",        32'(DD),        32'(e_dd));
    chk("cpu_ack",   32'(cpu_ack),   32'(e_ack));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
    chk("ram_addr",  32'(ram_addr),  32'(e_addr));
    chk("ram_we",    32'(ram_we),    32'(e_we));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
  endtask

  // One cycle: compare at the falling edge, then retire an acked request
  task automatic step(output bit acked);
    @(negedge clk_25);
    compare_all();
    acked = 1'b0;
    if (cpu_req && reset_n) begin
      if (cpu_ack) begin
        cpu_req  = 1'b0;
        acked    = 1'b1;
        wait_cyc = 0;
      end else begin
        wait_cyc++;
        if (wait_cyc > 40) begin
          chk("ack_timeout", 32'(wait_cyc), 32'd40);
          cpu_req  = 1'b0;
          wait_cyc = 0;
        end
      end
    end
  endtask

  task automatic tick();
    bit a;
    step(a);
  endtask

  task automatic wait_ack(output int lat);
    bit a;
    lat = 0;
    a   = 1'b0;
    while (!a && lat < 50) begin
      step(a);
      lat++;
    end
    if (!a) chk("wait_ack", 32'(lat), 32'd0);
  endtask

  task automatic issue(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    wait_cyc  = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int da_gap;
    logic [DATA_W-1:0] v;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = DATA_W'($urandom);
      mem[i] = v;
      smem[i] = v;
    end
    mem[0]     = 8'hA5; smem[0]     = 8'hA5;
    mem[1]     = 8'h11; smem[1]     = 8'h11;
    mem[2]     = 8'h12; smem[2]     = 8'h12;
    mem[5]     = 8'h00; smem[5]     = 8'h00;
    mem[13'h040] = 8'h77; smem[13'h040] = 8'h77;
    mem[13'h200] = 8'h5A; smem[13'h200] = 8'h5A;

    reset_n = 1'b0; DA = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset fetch of DA = 0
    repeat (3) tick();
    chk("reset_fetch_dd", 32'(DD), 32'h0A5);
    repeat (20) tick();

    // Display tracking
    DA = 13'h0001;
    repeat (4) tick();
    chk("track_dd_1", 32'(DD), 32'h011);
    repeat (16) tick();
    DA = 13'h0002;
    repeat (4) tick();
    chk("track_dd_2", 32'(DD), 32'h012);
    repeat (16) tick();

    // CPU write then read back (read presented in the ack cycle)
    issue(1'b1, 13'h0123, 8'h3C);
    tick();
    chk("wr_ram_we",   32'(ram_we),   32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h123);
    wait_ack(lat);
    chk("wr_ack_lat", 32'(lat + 1), 32'd2);
    issue(1'b0, 13'h0123, 8'h00);
    wait_ack(lat);
    chk("rd_ack_lat", 32'(lat), 32'd4);
    chk("rd_data",    32'(cpu_rdata), 32'h03C);
    repeat (5) tick();

    // Collision: DA change and a new read both appear in the ack cycle
    issue(1'b1, 13'h0300, 8'h99);
    wait_ack(lat);
    DA = 13'h0040;
    issue(1'b0, 13'h0200, 8'h00);
    repeat (2) tick();
    chk("coll_fetch_addr", 32'(ram_addr), 32'h040);
    wait_ack(lat);
    chk("coll_rd_lat",  32'(lat + 2), 32'd7);
    chk("coll_rd_data", 32'(cpu_rdata), 32'h05A);
    chk("coll_dd",      32'(DD), 32'h077);
    repeat (10) tick();

    // Write over the displayed byte refreshes DD
    DA = 13'h0005;
    repeat (25) tick();
    chk("wdisp_dd_before", 32'(DD), 32'h000);
    issue(1'b1, 13'h0005, 8'hFF);
    wait_ack(lat);
    repeat (4) tick();
    chk("wdisp_dd_after", 32'(DD), 32'h0FF);
    repeat (5) tick();

    // Reset while a read is in CPU_WAIT
    issue(1'b0, 13'h0200, 8'h00);
    tick();
    #5 reset_n = 1'b0;
    #1;
    chk("rst_dd",        32'(DD),        32'd0);
    chk("rst_cpu_ack",   32'(cpu_ack),   32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_ram_addr",  32'(ram_addr),  32'd0);
    repeat (2) tick();
    reset_n  = 1'b1;
    wait_cyc = 0;
    wait_ack(lat);
    chk("rst_reissue_data", 32'(cpu_rdata), 32'h05A);
    chk("rst_reissue_dd",   32'(DD),        32'h0FF);

    // Random traffic, including DA bursts faster than the generator's pace
    da_gap = 5;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!cpu_req && ($urandom % 3 == 0)) begin
        if ($urandom % 4 == 0)
          issue(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
        else
          issue(1'($urandom), ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
      end
      if (da_gap == 0) begin
        DA     = ADDR_W'($urandom_range(0, 31));
        da_gap = ($urandom % 4 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(10, 30));
      end else begin
        da_gap--;
      end
    end
    cpu_req = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
